lsu_ctrl: RTL



---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_load_extract.sv | 18 +
 rtl/lsu_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, funct3 codes and alignment helpers for the load/store unit.
package lsu_pkg;
  typedef enum logic [2:0] {IDLE, ACCESS, LD_LO, LD_HI, ST_BYTE, RESP} lsu_state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
              : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction
  function automatic logic is_aligned(input logic [1:0] off, input logic [2:0] f3);
    return f3[1] ? (off == 2'b00) : f3[0] ? !off[0] : 1'b1;
  endfunction
  function automatic logic [1:0] last_byte(input logic [2:0] f3);
    return f3[1] ? 2'd3 : f3[0] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/lsu_load_extract.sv
// lsu_load_extract: selects the addressed bytes from a two-word window and sign/zero-extends them.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [63:0] i_data,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_fun3,
  output logic [31:0] o_rdata
);
  logic [31:0] w_sh;
  assign w_sh = 32'(i_data >> {i_off, 3'b000});
  assign o_rdata = (i_fun3 == F3_B)  ? {{24{w_sh[7]}}, w_sh[7:0]}
                 : (i_fun3 == F3_H)  ? {{16{w_sh[15]}}, w_sh[15:0]}
                 : (i_fun3 == F3_W)  ? w_sh
                 : (i_fun3 == F3_BU) ? {24'h0, w_sh[7:0]}
                 : (i_fun3 == F3_HU) ? {16'h0, w_sh[15:0]}
                 : 32'h0;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller in front of a combinational-read data memory.
// Define LSU_SPLIT_EN to split misaligned accesses; otherwise they complete with an error.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_we,
  input  logic [WIDTH-1:0] i_req_addr,
  input  logic [WIDTH-1:0] i_req_wdata,
  input  logic [2:0]       i_req_fun3,
  output logic             o_resp_valid,
  output logic [WIDTH-1:0] o_resp_rdata,
  output logic             o_resp_err,
  output logic             o_mem_write,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  output logic [2:0]       o_mem_fun3,
  input  logic [WIDTH-1:0] i_mem_rdata
);
  lsu_state_t       r_state, w_next, w_ok_st;
  logic             r_we, r_err;
  logic [WIDTH-1:0] r_addr, r_wdata, r_rdata;
  logic [2:0]       r_fun3;
  logic             w_accept, w_legal, w_aligned, w_req_err;
  logic [63:0]      w_ext_in;
  logic [WIDTH-1:0] w_ext;
  assign w_accept  = i_req_valid && o_req_ready;
  assign w_legal   = f3_legal(i_req_we, i_req_fun3);
  assign w_aligned = is_aligned(i_req_addr[1:0], i_req_fun3);
`ifdef LSU_SPLIT_EN
  logic [WIDTH-1:0] r_lo;
  logic [1:0]       r_cnt;
  logic [7:0]       w_byte;
  assign w_req_err = !w_legal;
  assign w_ok_st   = w_aligned ? ACCESS : i_req_we ? ST_BYTE : LD_LO;
  assign w_ext_in  = (r_state == LD_HI) ? {i_mem_rdata, r_lo} : {32'h0, i_mem_rdata};
  assign w_byte    = 8'(r_wdata >> {r_cnt, 3'b000});
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_lo  <= '0;
      r_cnt <= '0;
    end else begin
      if (r_state == LD_LO) r_lo <= i_mem_rdata;
      r_cnt <= w_accept ? 2'd0 : (r_state == ST_BYTE) ? r_cnt + 2'd1 : r_cnt;
    end
`else
  assign w_req_err = !w_legal || !w_aligned;
  assign w_ok_st   = ACCESS;
  assign w_ext_in  = {32'h0, i_mem_rdata};
`endif
  lsu_load_extract u_extract (
    .i_data  (w_ext_in),
    .i_off   (r_addr[1:0]),
    .i_fun3  (r_fun3),
    .o_rdata (w_ext)
  );
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !i_req_valid ? IDLE : w_req_err ? RESP : w_ok_st;
      ACCESS:  w_next = RESP;
`ifdef LSU_SPLIT_EN
      LD_LO:   w_next = LD_HI;
      LD_HI:   w_next = RESP;
      ST_BYTE: w_next = (r_cnt == last_byte(r_fun3)) ? RESP : ST_BYTE;
`endif
      default: w_next = IDLE;
    endcase
  end
  // Response fields change only on entry to RESP so they hold between responses.
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_fun3  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= i_req_we;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_fun3  <= i_req_fun3;
      end
      if (w_next == RESP && r_state != RESP) begin
        r_err   <= (r_state == IDLE);
        r_rdata <= (r_state == IDLE || r_we) ? '0 : w_ext;
      end
    end
  always_comb begin
    o_req_ready  = (r_state == IDLE);
    o_resp_valid = (r_state == RESP);
    o_resp_rdata = r_rdata;
    o_resp_err   = r_err;
    o_mem_write  = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_mem_fun3   = '0;
    case (r_state)
      ACCESS: begin
        o_mem_write = r_we;
        o_mem_addr  = r_addr;
        o_mem_fun3  = r_fun3;
        o_mem_wdata = r_we ? r_wdata << {r_addr[1:0], 3'b000} : '0;
      end
`ifdef LSU_SPLIT_EN
      LD_LO: begin
        o_mem_addr = {r_addr[WIDTH-1:2], 2'b00};
        o_mem_fun3 = F3_W;
      end
      LD_HI: begin
        o_mem_addr = {r_addr[WIDTH-1:2], 2'b00} + WIDTH'(4);
        o_mem_fun3 = F3_W;
      end
      ST_BYTE: begin
        o_mem_write = 1'b1;
        o_mem_fun3  = F3_B;
        o_mem_addr  = r_addr + WIDTH'(r_cnt);
        o_mem_wdata = {4{w_byte}};
      end
`endif
      default: ;
    endcase
  end
endmodule
